seq_div_8by4: RTL and testbench

Sequential restoring divider: an 8-bit dividend divided by a 4-bit divisor gives an 8-bit quotient and a 4-bit remainder.
- It is the inverse of the 4x4 multiplier in the arithmetic library and reuses the same full-adder/ripple style for its trial subtraction.
- It produces one quotient bit per clock and uses a start/done handshake.
- It sits beside the adder/multiplier blocks as the library's division unit.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_sub_stage.sv | 29 ++
 rtl/full_adder.sv | 13 +
 rtl/seq_div_8by4.sv | 126 ++++++++++++
 tb/tb_seq_div_8by4.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and default widths for the sequential divider
package div_pkg;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;
    localparam int DEF_CNT_W      = $clog2(DEF_DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_sub_stage.sv
// rtl/div_sub_stage.sv - ripple trial subtractor a - b computed as a + ~b + 1
module div_sub_stage #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         no_borrow
);

    logic [W:0] carry;

    // Carry-in of 1 completes the two's complement of b.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (~b[i]),
            .cin  (carry[i]),
            .sum  (diff[i]),
            .cout (carry[i+1])
        );
    end

    // Carry out of the top bit means a >= b, i.e. no borrow.
    assign no_borrow = carry[W];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - library one-bit full-adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/seq_div_8by4.sv
// rtl/seq_div_8by4.sv - sequential restoring divider, one quotient bit per clock (option: DIV_ZERO_DETECT_EN)
module seq_div_8by4
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam int RW    = DIVISOR_W + 1;

    div_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] dvd_sr;
    logic [DIVISOR_W-1:0]  dsr_r;
    logic [DIVISOR_W-1:0]  rem_r;
    logic [DIVIDEND_W-1:0] quo_sr;

    logic [RW-1:0]         r_shift;
    logic [RW-1:0]         r_diff;
    logic                  no_borrow;
    logic [DIVISOR_W-1:0]  rem_next;
    logic [DIVIDEND_W-1:0] quo_next;
    logic                  last_iter;

    // Partial remainder picks up the next dividend bit, then trial-subtracts the divisor.
    assign r_shift = {rem_r, dvd_sr[DIVIDEND_W-1]};

    div_sub_stage #(
        .W (RW)
    ) u_sub (
        .a         (r_shift),
        .b         ({1'b0, dsr_r}),
        .diff      (r_diff),
        .no_borrow (no_borrow)
    );

    assign rem_next  = no_borrow ? r_diff[DIVISOR_W-1:0] : r_shift[DIVISOR_W-1:0];
    assign quo_next  = {quo_sr[DIVIDEND_W-2:0], no_borrow};
    assign last_iter = (cnt == CNT_W'(DIVIDEND_W - 1));

`ifdef DIV_ZERO_DETECT_EN
    logic dbz_r;
    assign div_by_zero = dbz_r;
`else
    assign div_by_zero = 1'b0;
`endif

    // FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd_sr    <= '0;
            dsr_r     <= '0;
            rem_r     <= '0;
            quo_sr    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dbz_r     <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    dvd_sr <= {dvd_sr[DIVIDEND_W-2:0], 1'b0};
                    rem_r  <= rem_next;
                    quo_sr <= quo_next;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= quo_next;
                        remainder <= rem_next;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_sr    <= dividend;
                        dsr_r     <= divisor;
                        rem_r     <= '0;
                        quo_sr    <= '0;
                        cnt       <= '0;
                        quotient  <= '0;
                        remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
                        dbz_r     <= 1'b0;
                        if (divisor == '0) begin
                            // Skip the iterations; the result matches what RUN would produce.
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend[DIVISOR_W-1:0];
                            dbz_r     <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
`else
                        state <= RUN;
                        busy  <= 1'b1;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_8by4.sv
// tb/tb_seq_div_8by4.sv - self-checking bench for seq_div_8by4 (honours DIV_ZERO_DETECT_EN)
module tb_seq_div_8by4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_div_8by4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Reference model: plain integer division, with the fixed divide-by-zero result.
    function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                  output logic [7:0] q, output logic [3:0] r,
                                  output logic dbz, output int lat);
        if (b == 0) begin
            q = 8'hFF;
            r = a[3:0];
`ifdef DIV_ZERO_DETECT_EN
            dbz = 1'b1;
            lat = 1;
`else
            dbz = 1'b0;
            lat = 9;
`endif
        end else begin
            q   = 8'(a / b);
            r   = 4'(a % b);
            dbz = 1'b0;
            lat = 9;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for done; reports what was observed.
    task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                         output logic [7:0] q, output logic [3:0] r,
                         output logic dbz, output int lat, output logic busy_bad);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        lat      = 1;
        busy_bad = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            tick();
            lat++;
        end
        if (busy !== 1'b0) busy_bad = 1'b1;
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
    endtask

    task automatic check_op(input string name, input logic [7:0] a, input logic [3:0] b);
        logic [7:0] q, eq;
        logic [3:0] r, er;
        logic       dbz, edbz, bb;
        int         lat, elat;
        model(a, b, eq, er, edbz, elat);
        do_op(a, b, q, r, dbz, lat, bb);
        n_checks++;
        if (lat !== elat) begin
            n_fail++;
            $display("FAIL %s latency %0d/%0d: got %0d expected %0d", name, a, b, lat, elat);
        end
        n_checks++;
        if ({q, r, dbz} !== {eq, er, edbz}) begin
            n_fail++;
            $display("FAIL %s result %0d/%0d: got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
                     name, a, b, q, r, dbz, eq, er, edbz);
        end
        n_checks++;
        if (bb !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy %0d/%0d: busy not high throughout the operation", name, a, b);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        tick();
        tick();
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        check_op("dir_200_7", 8'd200, 4'd7);
        check_op("dir_255_15", 8'd255, 4'd15);
        check_op("dir_9_13", 8'd9, 4'd13);
        tick();
        n_checks++;
        if (done !== 1'b0 || quotient !== 8'd0 || remainder !== 4'd9) begin
            n_fail++;
            $display("FAIL done_pulse_hold: got done=%0b q=%0d r=%0d expected done=0 q=0 r=9",
                     done, quotient, remainder);
        end
    endtask

    task automatic test_div_zero();
        check_op("div0_a5", 8'hA5, 4'd0);
        tick();
        check_op("div0_00", 8'h00, 4'd0);
        tick();
        check_op("div1_ff", 8'hFF, 4'd1);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        int         lat;
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 4'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd5;
        tick();
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;
        lat      = 4;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 9 || quotient !== 8'd33 || remainder !== 4'd1) begin
            n_fail++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d expected lat=9 q=33 r=1",
                     lat, quotient, remainder);
        end
        do_op(8'd50, 4'd5, q, r, dbz, lat, dbz);
        n_checks++;
        if (lat !== 9 || q !== 8'd10 || r !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d expected lat=9 q=10 r=0", lat, q, r);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%0b done=%0b q=%0d r=%0d expected all 0",
                     busy, done, quotient, remainder);
        end
        rst_n     = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL reset_abort: got %0d cycles with done/busy expected 0", seen_done);
        end
        check_op("after_reset", 8'd200, 4'd7);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            check_op("random", 8'($urandom), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 0) tick();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;
        test_reset();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
